// File: rtl/clutch_cam_timer.sv
`default_nettype none
// ============================================================================
// Module   : clutch_cam_timer
// Function : shaft angle counter, latch-point clutches, cam table, emitters
// Revision : 1.0 - initial release
// ============================================================================
module clutch_cam_timer #(
  parameter int DEG_PER_REV = 360,
  parameter int ANGLE_W     = 9,
  parameter int NUM_CLUTCH  = 2,
  parameter int LATCH_ANGLE = 315,
  parameter int NUM_CAMS    = 16,
  parameter int WIN_PER_CAM = 3,
  parameter int EMIT_FIRST  = 12,
  parameter int EMIT_PITCH  = 18,
  parameter int EMIT_WIDTH  = 2,
  parameter int EMIT_COUNT  = 12
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                power,
  input  logic [NUM_CLUTCH-1:0]                               clch_latch,
  input  logic                                                cfg_we,
  input  logic [((NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1)-1:0]  cfg_cam,
  input  logic [((WIN_PER_CAM > 1) ? $clog2(WIN_PER_CAM) : 1)-1:0] cfg_win,
  input  logic [$clog2(NUM_CLUTCH+1)-1:0]                     cfg_src,
  input  logic [ANGLE_W-1:0]                                  cfg_start,
  input  logic [ANGLE_W-1:0]                                  cfg_end,
  output logic [ANGLE_W-1:0]                                  cont_angle,
  output logic [NUM_CLUTCH*ANGLE_W-1:0]                       clch_angle,
  output logic [NUM_CLUTCH-1:0]                               clch_engaged,
  output logic [NUM_CLUTCH-1:0]                               clch_rev_done,
  output logic [NUM_CAMS-1:0]                                 cam_out,
  output logic [NUM_CLUTCH-1:0]                               emit
);

  localparam int c_SRC_W = $clog2(NUM_CLUTCH+1);
  localparam int c_PH_W  = (EMIT_PITCH > 1) ? $clog2(EMIT_PITCH) : 1;
  localparam int c_PU_W  = $clog2(EMIT_COUNT+1);

  localparam logic [ANGLE_W-1:0] c_LAST      = ANGLE_W'(DEG_PER_REV-1);
  localparam logic [ANGLE_W-1:0] c_LATCH     = ANGLE_W'(LATCH_ANGLE);
  localparam logic [ANGLE_W-1:0] c_PRE_LATCH = ANGLE_W'((LATCH_ANGLE+DEG_PER_REV-1) % DEG_PER_REV);
  localparam logic [ANGLE_W-1:0] c_EFIRST    = ANGLE_W'(EMIT_FIRST);

  localparam logic [0:0] c_ST_IDLE    = 1'b0;
  localparam logic [0:0] c_ST_ENGAGED = 1'b1;

  // Emitter counters must describe LATCH_ANGLE, where an idle clutch rests.
  localparam int          c_RST_OFF   = (LATCH_ANGLE >= EMIT_FIRST) ? LATCH_ANGLE-EMIT_FIRST : 0;
  localparam logic        c_RST_VALID = (LATCH_ANGLE >= EMIT_FIRST);
  localparam logic [c_PH_W-1:0] c_RST_PH = c_PH_W'(c_RST_OFF % EMIT_PITCH);
  localparam logic [c_PU_W-1:0] c_RST_PU =
      c_PU_W'(((c_RST_OFF / EMIT_PITCH) > EMIT_COUNT) ? EMIT_COUNT : (c_RST_OFF / EMIT_PITCH));

  logic [ANGLE_W-1:0] r_cont;
  logic [ANGLE_W-1:0] w_cont_next;
  logic               w_decide;

  always_comb begin
    w_cont_next = r_cont;
    if (power) w_cont_next = (r_cont == c_LAST) ? '0 : r_cont + 1'b1;
  end

  assign w_decide   = power && (r_cont == c_LATCH);
  assign cont_angle = r_cont;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cont <= '0;
    else     r_cont <= w_cont_next;
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CLUTCH; k++) begin : g_clutch
      logic [0:0]         r_state;
      logic [ANGLE_W-1:0] r_ang;
      logic               r_done;
      logic               r_emit;
      logic               r_valid;
      logic [c_PH_W-1:0]  r_ph;
      logic [c_PU_W-1:0]  r_pu;
      logic [0:0]         w_state_next;
      logic               w_adv;
      logic [ANGLE_W-1:0] w_ang_next;
      logic               w_valid_next;
      logic [c_PH_W-1:0]  w_ph_next;
      logic [c_PU_W-1:0]  w_pu_next;

      always_comb begin
        w_state_next = r_state;
        if (w_decide) w_state_next = clch_latch[k] ? c_ST_ENGAGED : c_ST_IDLE;
        w_adv      = power && (w_state_next == c_ST_ENGAGED);
        w_ang_next = w_adv ? w_cont_next : (power ? c_LATCH : r_ang);
        // Phase/pulse counters follow the clutch angle one step at a time.
        w_valid_next = r_valid;
        w_ph_next    = r_ph;
        w_pu_next    = r_pu;
        if (w_adv) begin
          if (w_cont_next == c_EFIRST) begin
            w_valid_next = 1'b1;
            w_ph_next    = '0;
            w_pu_next    = '0;
          end else if (w_cont_next == '0) begin
            w_valid_next = 1'b0;
            w_ph_next    = '0;
            w_pu_next    = '0;
          end else if (r_valid) begin
            if (32'(r_ph) == EMIT_PITCH-1) begin
              w_ph_next = '0;
              if (32'(r_pu) < EMIT_COUNT) w_pu_next = r_pu + 1'b1;
            end else begin
              w_ph_next = r_ph + 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= c_ST_IDLE;
          r_ang   <= c_LATCH;
          r_done  <= 1'b0;
          r_emit  <= 1'b0;
          r_valid <= c_RST_VALID;
          r_ph    <= c_RST_PH;
          r_pu    <= c_RST_PU;
        end else begin
          r_state <= w_state_next;
          r_ang   <= w_ang_next;
          r_done  <= power && (r_state == c_ST_ENGAGED) && (r_ang == c_PRE_LATCH);
          r_emit  <= (r_state == c_ST_ENGAGED) && r_valid &&
                     (32'(r_pu) < EMIT_COUNT) && (32'(r_ph) < EMIT_WIDTH);
          r_valid <= w_valid_next;
          r_ph    <= w_ph_next;
          r_pu    <= w_pu_next;
        end
      end

      assign clch_angle[k*ANGLE_W +: ANGLE_W] = r_ang;
      assign clch_engaged[k]                  = (r_state == c_ST_ENGAGED);
      assign clch_rev_done[k]                 = r_done;
      assign emit[k]                          = r_emit;
    end
  endgenerate

  logic [ANGLE_W-1:0] r_win_s   [NUM_CAMS][WIN_PER_CAM];
  logic [ANGLE_W-1:0] r_win_e   [NUM_CAMS][WIN_PER_CAM];
  logic [c_SRC_W-1:0] r_win_src [NUM_CAMS][WIN_PER_CAM];
  logic [ANGLE_W-1:0] w_src_ang [NUM_CLUTCH+1];
  logic [NUM_CAMS-1:0] w_cam;
  logic               w_cfg_ok;
  logic [NUM_CAMS-1:0] r_cam;

  assign w_cfg_ok = cfg_we && (32'(cfg_cam) < NUM_CAMS) && (32'(cfg_win) < WIN_PER_CAM) &&
                    (32'(cfg_src) <= NUM_CLUTCH) && (32'(cfg_start) < DEG_PER_REV) &&
                    (32'(cfg_end) < DEG_PER_REV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CAMS; c++) begin
        for (int w = 0; w < WIN_PER_CAM; w++) begin
          r_win_s[c][w]   <= '0;
          r_win_e[c][w]   <= '0;
          r_win_src[c][w] <= '0;
        end
      end
    end else if (w_cfg_ok) begin
      r_win_s[cfg_cam][cfg_win]   <= cfg_start;
      r_win_e[cfg_cam][cfg_win]   <= cfg_end;
      r_win_src[cfg_cam][cfg_win] <= cfg_src;
    end
  end

  // start==end never hits, which is how a cleared window stays disabled.
  function automatic logic win_hit(input logic [ANGLE_W-1:0] s, input logic [ANGLE_W-1:0] e,
                                   input logic [ANGLE_W-1:0] a);
    if (s < e)      return (a >= s) && (a < e);
    else if (s > e) return (a >= s) || (a < e);
    else            return 1'b0;
  endfunction

  always_comb begin
    w_src_ang[0] = r_cont;
    for (int i = 0; i < NUM_CLUTCH; i++) w_src_ang[i+1] = clch_angle[i*ANGLE_W +: ANGLE_W];
    w_cam = '0;
    for (int c = 0; c < NUM_CAMS; c++) begin
      for (int w = 0; w < WIN_PER_CAM; w++) begin
        if (win_hit(r_win_s[c][w], r_win_e[c][w], w_src_ang[r_win_src[c][w]])) w_cam[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cam <= '0;
    else     r_cam <= w_cam;
  end

  assign cam_out = r_cam;

endmodule
`default_nettype wire

// File: tb/tb_clutch_cam_timer.sv
`default_nettype none
// Directed testbench for clutch_cam_timer: one task per scenario, inline checks.
module tb_clutch_cam_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        power = 1'b0;
  logic [1:0]  clch_latch = 2'b00;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_cam = 4'd0;
  logic [1:0]  cfg_win = 2'd0;
  logic [1:0]  cfg_src = 2'd0;
  logic [8:0]  cfg_start = 9'd0;
  logic [8:0]  cfg_end = 9'd0;
  logic [8:0]  cont_angle;
  logic [17:0] clch_angle;
  logic [1:0]  clch_engaged;
  logic [1:0]  clch_rev_done;
  logic [15:0] cam_out;
  logic [1:0]  emit;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clutch_cam_timer dut (
    .clk(clk), .rst(rst), .power(power), .clch_latch(clch_latch),
    .cfg_we(cfg_we), .cfg_cam(cfg_cam), .cfg_win(cfg_win), .cfg_src(cfg_src),
    .cfg_start(cfg_start), .cfg_end(cfg_end),
    .cont_angle(cont_angle), .clch_angle(clch_angle), .clch_engaged(clch_engaged),
    .clch_rev_done(clch_rev_done), .cam_out(cam_out), .emit(emit)
  );

  function automatic logic cam0_exp(input int a);
    return (a >= 340) || (a < 93);
  endfunction

  function automatic logic emit_exp(input int a);
    return (a >= 12) && (((a - 12) % 18) < 2) && (((a - 12) / 18) < 12);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int ang);
    int guard = 0;
    while (cont_angle !== 9'(ang) && guard < 800) begin
      tick();
      guard++;
    end
    n_assert++;
    if (cont_angle !== 9'(ang)) begin
      n_fail++;
      $display("FAIL run_to: cont_angle=%0d required %0d within 800 cycles", cont_angle, ang);
    end
  endtask

  task automatic cfg_write(input logic [3:0] cam, input logic [1:0] win, input logic [1:0] src,
                           input logic [8:0] s, input logic [8:0] e);
    cfg_cam = cam; cfg_win = win; cfg_src = src; cfg_start = s; cfg_end = e;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; power = 1'b1; clch_latch = 2'b00;
    repeat (3) tick();
    n_assert++;
    if (cont_angle !== 9'd0 || clch_angle !== {9'd315, 9'd315} || clch_engaged !== 2'b00 ||
        clch_rev_done !== 2'b00 || cam_out !== 16'h0000 || emit !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_values: cont=%0d clch=%h eng=%b done=%b cam=%h emit=%b required 0 %h 00 00 0000 00",
               cont_angle, clch_angle, clch_engaged, clch_rev_done, cam_out, emit, {9'd315, 9'd315});
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 720; i++) begin
      tick();
      n_assert++;
      if (cont_angle !== 9'(i % 360) || clch_angle !== {9'd315, 9'd315} ||
          clch_engaged !== 2'b00 || clch_rev_done !== 2'b00) begin
        n_fail++;
        $display("FAIL free_run step %0d: cont=%0d clch=%h eng=%b done=%b required cont=%0d clch=315/315 eng=00 done=00",
                 i, cont_angle, clch_angle, clch_engaged, clch_rev_done, i % 360);
      end
    end
  endtask

  task automatic test_engage_release();
    run_to(200);
    clch_latch = 2'b01;
    run_to(315);
    n_assert++;
    if (clch_engaged !== 2'b00 || clch_angle[8:0] !== 9'd315) begin
      n_fail++;
      $display("FAIL pre_engage: eng=%b clch0=%0d required 00 315", clch_engaged, clch_angle[8:0]);
    end
    tick();
    n_assert++;
    if (clch_engaged !== 2'b01 || clch_angle[8:0] !== 9'd316) begin
      n_fail++;
      $display("FAIL engage: eng=%b clch0=%0d required 01 316", clch_engaged, clch_angle[8:0]);
    end
    tick();
    n_assert++;
    if (clch_angle[8:0] !== 9'd317) begin
      n_fail++;
      $display("FAIL track: clch0=%0d required 317", clch_angle[8:0]);
    end
    run_to(314);
    n_assert++;
    if (clch_rev_done !== 2'b00 || clch_angle[8:0] !== 9'd314) begin
      n_fail++;
      $display("FAIL before_rev: done=%b clch0=%0d required 00 314", clch_rev_done, clch_angle[8:0]);
    end
    tick();
    n_assert++;
    if (clch_rev_done !== 2'b01 || clch_angle[8:0] !== 9'd315) begin
      n_fail++;
      $display("FAIL rev_done: done=%b clch0=%0d required 01 315", clch_rev_done, clch_angle[8:0]);
    end
    tick();
    n_assert++;
    if (clch_engaged !== 2'b01 || clch_rev_done !== 2'b00 || clch_angle[8:0] !== 9'd316) begin
      n_fail++;
      $display("FAIL multi_rev: eng=%b done=%b clch0=%0d required 01 00 316",
               clch_engaged, clch_rev_done, clch_angle[8:0]);
    end
    run_to(100);
    clch_latch = 2'b00;
    run_to(315);
    n_assert++;
    if (clch_rev_done !== 2'b01 || clch_engaged !== 2'b01) begin
      n_fail++;
      $display("FAIL last_rev: done=%b eng=%b required 01 01", clch_rev_done, clch_engaged);
    end
    tick();
    n_assert++;
    if (clch_engaged !== 2'b00 || clch_angle[8:0] !== 9'd315 || cont_angle !== 9'd316) begin
      n_fail++;
      $display("FAIL release: eng=%b clch0=%0d cont=%0d required 00 315 316",
               clch_engaged, clch_angle[8:0], cont_angle);
    end
    repeat (10) tick();
    n_assert++;
    if (clch_engaged !== 2'b00 || clch_angle[8:0] !== 9'd315) begin
      n_fail++;
      $display("FAIL hold_after_release: eng=%b clch0=%0d required 00 315", clch_engaged, clch_angle[8:0]);
    end
  endtask

  task automatic test_latch_ignored();
    run_to(100);
    clch_latch = 2'b01;
    run_to(200);
    clch_latch = 2'b00;
    run_to(315);
    tick();
    n_assert++;
    if (clch_engaged !== 2'b00) begin
      n_fail++;
      $display("FAIL latch_outside_decision: eng=%b required 00", clch_engaged);
    end
  endtask

  task automatic test_cam_table();
    cfg_write(4'd0, 2'd0, 2'd0, 9'd8, 9'd93);
    cfg_write(4'd0, 2'd1, 2'd0, 9'd340, 9'd65);
    cfg_write(4'd0, 2'd2, 2'd0, 9'd100, 9'd100);
    cfg_write(4'd0, 2'd0, 2'd0, 9'd8, 9'd400);
    cfg_write(4'd0, 2'd2, 2'd0, 9'd360, 9'd200);
    cfg_write(4'd1, 2'd0, 2'd3, 9'd0, 9'd180);
    run_to(0);
    for (int i = 0; i < 360; i++) begin
      tick();
      n_assert++;
      if (cam_out !== {15'd0, cam0_exp(i)}) begin
        n_fail++;
        $display("FAIL cam_scan angle=%0d: cam_out=%h required %h", i, cam_out, {15'd0, cam0_exp(i)});
      end
    end
  endtask

  task automatic test_emitter();
    int pulses = 0;
    run_to(200);
    clch_latch = 2'b10;
    run_to(315);
    n_assert++;
    if (emit !== 2'b00) begin
      n_fail++;
      $display("FAIL emit_idle: emit=%b required 00", emit);
    end
    tick();
    n_assert++;
    if (clch_engaged !== 2'b10) begin
      n_fail++;
      $display("FAIL engage_c1: eng=%b required 10", clch_engaged);
    end
    run_to(0);
    for (int i = 0; i < 360; i++) begin
      tick();
      if (emit[1] === 1'b1) pulses++;
      n_assert++;
      if (emit !== {emit_exp(i), 1'b0}) begin
        n_fail++;
        $display("FAIL emit angle=%0d: emit=%b required %b", i, emit, {emit_exp(i), 1'b0});
      end
    end
    n_assert++;
    if (pulses != 24) begin
      n_fail++;
      $display("FAIL emit_count: high cycles=%0d required 24", pulses);
    end
  endtask

  task automatic test_power();
    run_to(50);
    power = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_assert++;
      if (cont_angle !== 9'd50 || clch_angle !== {9'd50, 9'd315} || clch_engaged !== 2'b10 ||
          clch_rev_done !== 2'b00 || cam_out !== 16'h0001 || emit !== 2'b00) begin
        n_fail++;
        $display("FAIL frozen cycle %0d: cont=%0d clch=%h eng=%b done=%b cam=%h emit=%b required 50 %h 10 00 0001 00",
                 i, cont_angle, clch_angle, clch_engaged, clch_rev_done, cam_out, emit, {9'd50, 9'd315});
      end
    end
    power = 1'b1;
    tick();
    n_assert++;
    if (cont_angle !== 9'd51 || clch_angle[17:9] !== 9'd51) begin
      n_fail++;
      $display("FAIL resume: cont=%0d clch1=%0d required 51 51", cont_angle, clch_angle[17:9]);
    end
    run_to(315);
    power = 1'b0;
    clch_latch = 2'b00;
    repeat (5) tick();
    n_assert++;
    if (cont_angle !== 9'd315 || clch_engaged !== 2'b10 || clch_rev_done !== 2'b00 ||
        clch_angle[17:9] !== 9'd315) begin
      n_fail++;
      $display("FAIL deferred_hold: cont=%0d eng=%b done=%b clch1=%0d required 315 10 00 315",
               cont_angle, clch_engaged, clch_rev_done, clch_angle[17:9]);
    end
    power = 1'b1;
    tick();
    n_assert++;
    if (clch_engaged !== 2'b00 || cont_angle !== 9'd316 || clch_angle[17:9] !== 9'd315) begin
      n_fail++;
      $display("FAIL deferred_release: eng=%b cont=%0d clch1=%0d required 00 316 315",
               clch_engaged, cont_angle, clch_angle[17:9]);
    end
  endtask

  task automatic test_two_channel();
    cfg_write(4'd6, 2'd0, 2'd2, 9'd315, 9'd316);
    tick();
    run_to(200);
    n_assert++;
    if (cam_out[6] !== 1'b1) begin
      n_fail++;
      $display("FAIL src_idle_clutch: cam6=%b required 1", cam_out[6]);
    end
    clch_latch = 2'b10;
    run_to(315);
    cfg_cam = 4'd5; cfg_win = 2'd0; cfg_src = 2'd2; cfg_start = 9'd316; cfg_end = 9'd318;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    n_assert++;
    if (clch_engaged !== 2'b10 || cont_angle !== 9'd316 || cam_out[6:5] !== 2'b10) begin
      n_fail++;
      $display("FAIL engage_with_cfg: eng=%b cont=%0d cam6:5=%b required 10 316 10",
               clch_engaged, cont_angle, cam_out[6:5]);
    end
    tick();
    n_assert++;
    if (cam_out[6:5] !== 2'b01) begin
      n_fail++;
      $display("FAIL cfg_land: cam6:5=%b required 01", cam_out[6:5]);
    end
    tick();
    n_assert++;
    if (cam_out[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL cam5_317: cam5=%b required 1", cam_out[5]);
    end
    tick();
    n_assert++;
    if (cam_out[5] !== 1'b0 || clch_engaged[0] !== 1'b0 || clch_angle[8:0] !== 9'd315) begin
      n_fail++;
      $display("FAIL cam5_end_c0_idle: cam5=%b eng0=%b clch0=%0d required 0 0 315",
               cam_out[5], clch_engaged[0], clch_angle[8:0]);
    end
  endtask

  task automatic test_reset_mid();
    run_to(50);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_assert++;
    if (cont_angle !== 9'd0 || clch_angle !== {9'd315, 9'd315} || clch_engaged !== 2'b00 ||
        clch_rev_done !== 2'b00 || cam_out !== 16'h0000 || emit !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: cont=%0d clch=%h eng=%b done=%b cam=%h emit=%b required 0 %h 00 00 0000 00",
               cont_angle, clch_angle, clch_engaged, clch_rev_done, cam_out, emit, {9'd315, 9'd315});
    end
    tick();
    rst = 1'b0;
    clch_latch = 2'b00;
    tick();
    n_assert++;
    if (cont_angle !== 9'd1 || clch_angle !== {9'd315, 9'd315}) begin
      n_fail++;
      $display("FAIL post_reset_step: cont=%0d clch=%h required 1 %h", cont_angle, clch_angle, {9'd315, 9'd315});
    end
    for (int i = 0; i < 360; i++) begin
      tick();
      n_assert++;
      if (cam_out !== 16'h0000 || emit !== 2'b00) begin
        n_fail++;
        $display("FAIL table_cleared step %0d: cam=%h emit=%b required 0000 00", i, cam_out, emit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_engage_release();
    test_latch_ignored();
    test_cam_table();
    test_emitter();
    test_power();
    test_two_channel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
